req_encoder8_3: RTL and testbench

REQ_ENCODER8_3 -- requirements
Module: req_encoder8_3

---
 rtl/req_encoder8_3_pkg.sv | 13 +
 rtl/req_encoder8_3_prio_enc8_3.sv | 22 ++
 rtl/req_encoder8_3.sv | 98 +++++++++
 tb/tb_req_encoder8_3.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder8_3_pkg.sv
// Shared types and constants for the request encoder.
// Holds the FSM state enum and the request/code widths.
package req_encoder8_3_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/req_encoder8_3_prio_enc8_3.sv
// Combinational 8-to-3 priority encoder.
// Highest set index wins; any flags a non-empty input.
module prio_enc8_3
    import req_encoder8_3_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder8_3.sv
// Request collector that presents one pending index at a time.
// Code/valid are held until ack; served counts accepted codes.
module req_encoder8_3
    import req_encoder8_3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic               en,
    input  logic               ack,
    output logic [CODE_W-1:0]  code,
    output logic               valid,
    output logic [N_REQ-1:0]   pending,
    output logic               dropped,
    output logic [CNT_W-1:0]   served
);

    state_t              state;
    state_t              state_d;
    logic [CODE_W-1:0]   code_d;
    logic                valid_d;
    logic [N_REQ-1:0]    clr_mask;
    logic [N_REQ-1:0]    pending_d;
    logic                dropped_d;
    logic [CNT_W-1:0]    served_d;
    logic [CODE_W-1:0]   enc_idx;
    logic                enc_any;

    prio_enc8_3 u_prio (
        .req (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Clear only the presented bit, and only on an accepted code.
    always_comb begin
        clr_mask = '0;
        if (valid && ack) begin
            clr_mask[code] = 1'b1;
        end
    end

    // New requests win over a same-cycle clear; repeats mark a drop.
    always_comb begin
        pending_d = (pending & ~clr_mask) | req;
        dropped_d = dropped | (|(req & pending & ~clr_mask));
    end

    // Present from registered pending; hold until acknowledged.
    always_comb begin
        state_d  = state;
        code_d   = code;
        valid_d  = valid;
        served_d = served;
        unique case (state)
            IDLE: begin
                if (en && enc_any) begin
                    state_d = PRESENT;
                    code_d  = enc_idx;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    served_d = served + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // All state lives here; reset abandons any presented code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            code    <= '0;
            valid   <= 1'b0;
            pending <= '0;
            dropped <= 1'b0;
            served  <= '0;
        end else begin
            state   <= state_d;
            code    <= code_d;
            valid   <= valid_d;
            pending <= pending_d;
            dropped <= dropped_d;
            served  <= served_d;
        end
    end

endmodule

// File: tb/tb_req_encoder8_3.sv
// Self-checking bench for req_encoder8_3 (CNT_W=2).
// Directed scenarios followed by randomized traffic vs a model.
module tb_req_encoder8_3;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       req = '0;
    logic             en  = 1'b0;
    logic             ack = 1'b0;
    logic [2:0]       code;
    logic             valid;
    logic [7:0]       pending;
    logic             dropped;
    logic [CNT_W-1:0] served;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_pending = '0;
    logic       m_valid   = 1'b0;
    int         m_code    = 0;
    int         m_served  = 0;
    logic       m_dropped = 1'b0;

    req_encoder8_3 #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (en),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .dropped (dropped),
        .served  (served)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_valid   = 1'b0;
        m_code    = 0;
        m_served  = 0;
        m_dropped = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, int'(valid), int'(m_valid));
        chk({tag, ".pending"}, int'(pending), int'(m_pending));
        chk({tag, ".dropped"}, int'(dropped), int'(m_dropped));
        chk({tag, ".served"}, int'(served), m_served);
        if (m_valid) begin
            chk({tag, ".code"}, int'(code), m_code);
        end
    endtask

    // Called at a falling edge: drive, advance one rising edge, check.
    task automatic cycle(input string tag, input logic [7:0] r,
                         input logic e, input logic a);
        logic [7:0] clr;
        logic [7:0] old_p;
        req = r;
        en  = e;
        ack = a;
        old_p = m_pending;
        clr = '0;
        if (m_valid && a) clr = 8'(1) << m_code;
        if ((r & old_p & ~clr) != 0) m_dropped = 1'b1;
        m_pending = (old_p & ~clr) | r;
        if (!m_valid) begin
            if (e && old_p != 0) begin
                m_valid = 1'b1;
                m_code  = highest(old_p);
            end
        end else if (a) begin
            m_valid  = 1'b0;
            m_served = (m_served + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = '0;
        en  = 1'b0;
        ack = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_code"}, int'(code), 0);
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");

        // Single request: valid on 2nd edge, code 2, ack clears.
        do_reset("single_rst");
        cycle("single_cap", 8'h04, 1'b1, 1'b0);
        cycle("single_pres", 8'h00, 1'b1, 1'b0);
        chk("single_code2", int'(code), 2);
        cycle("single_ack", 8'h00, 1'b1, 1'b1);
        chk("single_served1", int'(served), 1);

        // Priority and stability.
        do_reset("prio_rst");
        cycle("prio_cap", 8'h81, 1'b1, 1'b0);
        cycle("prio_pres", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle("prio_hold", 8'h00, i[0], 1'b0);
            chk("prio_code7", int'(code), 7);
        end
        cycle("prio_ack7", 8'h00, 1'b1, 1'b1);
        cycle("prio_next", 8'h00, 1'b1, 1'b0);
        chk("prio_code0", int'(code), 0);
        cycle("prio_ack0", 8'h00, 1'b1, 1'b1);
        chk("prio_served2", int'(served), 2);

        // Set-wins collision on the acknowledged bit.
        do_reset("coll_rst");
        cycle("coll_cap", 8'h08, 1'b1, 1'b0);
        cycle("coll_pres", 8'h00, 1'b1, 1'b0);
        cycle("coll_ack", 8'h08, 1'b1, 1'b1);
        chk("coll_pend3", int'(pending[3]), 1);
        cycle("coll_repres", 8'h00, 1'b1, 1'b0);
        chk("coll_code3", int'(code), 3);
        cycle("coll_ack2", 8'h00, 1'b1, 1'b1);

        // Drop detection is sticky until reset.
        do_reset("drop_rst");
        cycle("drop_cap", 8'h20, 1'b0, 1'b0);
        cycle("drop_dup", 8'h20, 1'b0, 1'b0);
        chk("drop_set", int'(dropped), 1);
        for (int i = 0; i < 3; i++) begin
            cycle("drop_hold", 8'h00, 1'b1, 1'b1);
        end
        do_reset("drop_clr");

        // Gating then drain all eight codes, served wraps.
        do_reset("wrap_rst");
        cycle("gate_cap", 8'hFF, 1'b0, 1'b0);
        cycle("gate_idle", 8'h00, 1'b0, 1'b1);
        chk("gate_pendFF", int'(pending), 8'hFF);
        for (int i = 0; i < 8; i++) begin
            cycle("wrap_pres", 8'h00, 1'b1, 1'b0);
            chk("wrap_code", int'(code), 7 - i);
            cycle("wrap_ack", 8'h00, 1'b1, 1'b1);
            chk("wrap_served", int'(served), (i + 1) % 4);
        end

        // Async reset while presenting.
        do_reset("async_rst0");
        cycle("async_cap", 8'h10, 1'b1, 1'b0);
        cycle("async_pres", 8'h00, 1'b1, 1'b0);
        #2;
        do_reset("async_mid");
        cycle("async_quiet", 8'h00, 1'b1, 1'b0);
        cycle("async_quiet2", 8'h00, 1'b1, 1'b0);
        cycle("async_newreq", 8'h02, 1'b1, 1'b0);
        cycle("async_newpres", 8'h00, 1'b1, 1'b0);
        chk("async_code1", int'(code), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle("rand", r, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
            if (i == 200) do_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
